// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit.
//   op_e        : RV32M funct3 encodings (MUL..REMU)
//   state_e     : controller state encoding (IDLE, CALC, FIX, DONE)
//   ITERATIONS  : number of radix-2 iterations per normal operation
package muldiv_seq_pkg;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CntW       = $clog2(ITERATIONS);

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core and the multiply/divide unit.
//   start  : request to begin an operation
//   op     : RV32M funct3
//   a, b   : rs1 / rs2 operand values
//   kill   : pipeline flush, aborts the operation in progress
//   busy   : unit is computing (core stalls)
//   done   : one-cycle pulse, result valid
//   result : last completed result
// master = core side, slave = the unit.
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// Multiply: radix-2 shift-add on operand magnitudes, 32 iterations.
// Divide:   restoring radix-2 on operand magnitudes, 32 iterations.
// Both share one 64-bit accumulator and one 33-bit adder/subtractor; signs are
// reapplied in a single FIX cycle. Divide-by-zero and signed overflow skip the
// iterations and go straight to FIX.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : muldiv_seq_if slave (start/op/a/b/kill in, busy/done/result out)
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    op_e               op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_mag_q;
    logic              neg_q;
    logic              special_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;

    // Incoming request decode
    logic            can_accept, accept;
    logic            a_signed_in, b_signed_in, sign_a_in, sign_b_in;
    logic            is_div_in, is_rem_in, ovf_in, special_in, neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;

    always_comb begin
        can_accept  = (state_q == StIdle) || (state_q == StDone);
        accept      = can_accept && bus.start && !bus.kill;
        is_div_in   = bus.op[2];
        is_rem_in   = (bus.op == OpRem) || (bus.op == OpRemu);
        a_signed_in = (bus.op == OpMul) || (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                      (bus.op == OpDiv) || (bus.op == OpRem);
        b_signed_in = (bus.op == OpMul) || (bus.op == OpMulh) ||
                      (bus.op == OpDiv) || (bus.op == OpRem);
        sign_a_in   = a_signed_in && bus.a[XLEN-1];
        sign_b_in   = b_signed_in && bus.b[XLEN-1];
        a_mag_in    = sign_a_in ? (~bus.a + 1'b1) : bus.a;
        b_mag_in    = sign_b_in ? (~bus.b + 1'b1) : bus.b;
        ovf_in      = ((bus.op == OpDiv) || (bus.op == OpRem)) &&
                      (bus.a == MinNeg) && (bus.b == {XLEN{1'b1}});
        special_in  = is_div_in && ((bus.b == '0) || ovf_in);
        // Remainder takes the dividend's sign; product and quotient take signA ^ signB.
        neg_in      = is_rem_in ? sign_a_in : (sign_a_in ^ sign_b_in);
    end

    // Shared 33-bit adder/subtractor and iteration step
    logic            is_div_q;
    logic [XLEN:0]   add_x, add_y, add_sum;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        is_div_q = op_q[2];
        // Divide looks at the remainder shifted left by one with the next dividend bit.
        add_x    = is_div_q ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        add_y    = {1'b0, b_mag_q};
        add_sum  = add_x + (add_y ^ {(XLEN+1){is_div_q}}) + {{XLEN{1'b0}}, is_div_q};
        if (is_div_q) begin
            // add_sum[XLEN] set means borrow: restore by keeping the shifted remainder.
            if (!add_sum[XLEN]) begin
                acc_next = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_next = {add_sum, acc_q[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_result;

    always_comb begin
        prod       = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo        = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem        = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        fix_result = '0;
        unique case (op_q)
            OpMul: fix_result = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_result = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu: begin
                if (special_q) begin
                    // b magnitude 0 means divide by zero, otherwise signed overflow.
                    fix_result = (b_mag_q == '0) ? {XLEN{1'b1}} : MinNeg;
                end else begin
                    fix_result = quo;
                end
            end
            OpRem, OpRemu: begin
                if (special_q) begin
                    fix_result = (b_mag_q == '0) ? a_q : '0;
                end else begin
                    fix_result = rem;
                end
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d = special_in ? StFix : StCalc;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end
                end
                StFix: state_d = StDone;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.busy   = (state_q == StCalc) || (state_q == StFix);
        bus.done   = (state_q == StDone);
        bus.result = result_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= OpMul;
            a_q       <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                op_q      <= op_e'(bus.op);
                a_q       <= bus.a;
                b_mag_q   <= b_mag_in;
                neg_q     <= neg_in;
                special_q <= special_in;
                acc_q     <= {{XLEN{1'b0}}, a_mag_in};
                cnt_q     <= special_in ? '0 : CntW'(ITERATIONS - 1);
            end else if ((state_q == StCalc) && !bus.kill) begin
                acc_q <= acc_next;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if ((state_q == StFix) && !bus.kill) begin
                result_q <= fix_result;
            end
        end
    end

endmodule
